// File: rtl/timer_pkg.sv
// Shared types for the oven timer entry path: BCD digit, key sentinel,
// debouncer state encoding and the packed MM:SS entry register.
package timer_pkg;

   typedef logic [3:0] bcd_t;

   localparam bcd_t KEY_NONE      = 4'hF;
   localparam bcd_t KEY_MAX_DIGIT = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_DEBOUNCE     = 2'd1,
      ST_ACCEPT       = 2'd2,
      ST_WAIT_RELEASE = 2'd3
   } db_state_t;

   typedef struct packed {
      bcd_t min_tens;
      bcd_t min_ones;
      bcd_t sec_tens;
      bcd_t sec_ones;
   } entry_t;

   // Codes A..E leak out of the encoder on multi-key presses; only 0..9 count.
   function automatic logic key_is_digit(input logic no_key, input bcd_t code);
      return !no_key && (code <= KEY_MAX_DIGIT);
   endfunction

   // New digit enters at seconds units; the oldest (minutes tens) falls off.
   function automatic entry_t shift_in(input entry_t cur, input bcd_t d);
      entry_t nxt;
      nxt.min_tens = cur.min_ones;
      nxt.min_ones = cur.sec_tens;
      nxt.sec_tens = cur.sec_ones;
      nxt.sec_ones = d;
      return nxt;
   endfunction

endpackage

// File: rtl/key_debouncer.sv
// Keypad debouncer: a digit must hold for DEBOUNCE_CYCLES clocks before it is
// accepted once; it then must be released before another key can count.
module key_debouncer
   import timer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       entry_en,
   input  logic       clear_entry,
   input  logic [3:0] key_code,
   input  logic       no_key,
   output logic       accept_pulse,
   output logic [3:0] accepted_code
);

   localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);

   db_state_t        state;
   bcd_t             cand;
   logic [CNT_W-1:0] cnt;
   logic             key_present;
   logic             cnt_done;

   assign key_present = key_is_digit(no_key, key_code);
   assign cnt_done    = (cnt == DB_LIMIT);

   // Fires on the edge that moves DEBOUNCE -> ACCEPT so the shifted digits and
   // the strobe are both visible during the ACCEPT cycle. A disable or clear in
   // that same cycle suppresses it.
   assign accept_pulse  = entry_en && !clear_entry && (state == ST_DEBOUNCE) &&
                          key_present && (key_code == cand) && cnt_done;
   assign accepted_code = cand;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // branch below reads the pre-edge values of state, cand and cnt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cand  <= KEY_NONE;
         cnt   <= '0;
      end else if (!entry_en) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else if (clear_entry) begin
         state <= ST_WAIT_RELEASE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (key_present) begin
                  cand  <= key_code;
                  cnt   <= CNT_W'(1);
                  state <= ST_DEBOUNCE;
               end
            end
            ST_DEBOUNCE: begin
               if (!key_present) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else if (key_code != cand) begin
                  cand <= key_code;
                  cnt  <= CNT_W'(1);
               end else if (cnt_done) begin
                  state <= ST_ACCEPT;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_ACCEPT: begin
               state <= ST_WAIT_RELEASE;
               cnt   <= '0;
            end
            ST_WAIT_RELEASE: begin
               if (!key_present) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/timer_digit_register.sv
// MM:SS keypad entry register: debounced digits shift in from the right, one per
// stable key press, and feed the countdown stage downstream.
module timer_digit_register
   import timer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       entry_en,
   input  logic       clear_entry,
   input  logic [3:0] key_code,
   input  logic       no_key,
   output logic       encoder_enablen,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [3:0] min_tens,
   output logic       digit_strobe,
   output logic       entry_nonzero
);

   logic   accept_pulse;
   bcd_t   accepted_code;
   entry_t digits;

   key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_debouncer (
      .clk          (clk),
      .rst_n        (rst_n),
      .entry_en     (entry_en),
      .clear_entry  (clear_entry),
      .key_code     (key_code),
      .no_key       (no_key),
      .accept_pulse (accept_pulse),
      .accepted_code(accepted_code)
   );

   // Digits are not range-checked; seconds-tens above 5 is normalised downstream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digits          <= '0;
         digit_strobe    <= 1'b0;
         encoder_enablen <= 1'b1;
      end else begin
         encoder_enablen <= ~entry_en;
         digit_strobe    <= accept_pulse;
         if (clear_entry) begin
            digits <= '0;
         end else if (accept_pulse) begin
            digits <= shift_in(digits, accepted_code);
         end
      end
   end

   assign sec_ones      = digits.sec_ones;
   assign sec_tens      = digits.sec_tens;
   assign min_ones      = digits.min_ones;
   assign min_tens      = digits.min_tens;
   assign entry_nonzero = |digits;

endmodule
